countdown_timer: RTL

//  Min:sec countdown timer driven by the shared 1 kHz enable pulse. User sets min/sec with

---
 rtl/countdown_timer_pkg.sv | 26 ++
 rtl/countdown_timer_sec_tick_gen.sv | 39 +++
 rtl/countdown_timer.sv | 113 +++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared encodings and time helpers for the min:sec countdown timer and its display decoder.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam logic [5:0] SEC_MAX = 6'd59;

   // One-second decrement of {min,sec}; caller guarantees the time is not 00:00.
   function automatic logic [11:0] dec_time(input logic [5:0] min_v, input logic [5:0] sec_v);
      logic [5:0] m;
      logic [5:0] s;
      if (sec_v == 6'd0) begin
         m = min_v - 6'd1;
         s = SEC_MAX;
      end else begin
         m = min_v;
         s = sec_v - 6'd1;
      end
      return {m, s};
   endfunction

endpackage

// File: rtl/countdown_timer_sec_tick_gen.sv
// Millisecond prescaler: counts enabled 1 kHz pulses and flags the pulse that completes a second.
module sec_tick_gen #(
   parameter int MS_PER_SEC = 1000
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_en,
   input  logic i_clr,
   output logic o_last,
   output logic o_tick
);

   localparam int CW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MS_PER_SEC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_last = (cnt_q == CNT_LAST);
   assign o_tick = i_en & o_last;

endmodule

// File: rtl/countdown_timer.sv
// Min:sec countdown timer: button-set time, start/pause/resume, clear, one-cycle done pulse at expiry.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int MS_PER_SEC = 1000,
   parameter int MAX_MIN    = 59
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_pls_1k,
   input  logic       i_start,
   input  logic       i_clear,
   input  logic       i_min_up,
   input  logic       i_sec_up,
   output logic [5:0] o_min,
   output logic [5:0] o_sec,
   output logic       o_run,
   output logic       o_done
);

   state_e     state_q, state_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       done_q, done_d;

   logic       time_zero;
   logic       one_sec;
   logic       ms_last;
   logic       tick;
   logic       final_dec;
   logic       tick_en;
   logic       ms_clr;

   assign time_zero = (min_q == 6'd0) && (sec_q == 6'd0);
   assign one_sec   = (min_q == 6'd0) && (sec_q == 6'd1);
   assign final_dec = (state_q == ST_RUN) && i_pls_1k && ms_last && one_sec;

   // A start in RUN pauses instead of counting, unless this pulse expires the timer.
   assign tick_en = (state_q == ST_RUN) && i_pls_1k && !i_clear && (!i_start || final_dec);
   assign ms_clr  = i_clear || ((state_q == ST_IDLE) && i_start && !time_zero);

   sec_tick_gen #(
      .MS_PER_SEC(MS_PER_SEC)
   ) u_sec_tick_gen (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .i_en  (tick_en),
      .i_clr (ms_clr),
      .o_last(ms_last),
      .o_tick(tick)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (i_start && !time_zero) state_d = ST_RUN;
            ST_RUN: begin
               if (final_dec)    state_d = ST_IDLE;
               else if (i_start) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (i_start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      min_d  = min_q;
      sec_d  = sec_q;
      done_d = 1'b0;
      if (i_clear) begin
         min_d = 6'd0;
         sec_d = 6'd0;
      end else if ((state_q == ST_IDLE) && !i_start) begin
         if (i_min_up) min_d = (min_q == 6'(MAX_MIN)) ? 6'd0 : min_q + 6'd1;
         if (i_sec_up) sec_d = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
      end else if (tick) begin
         {min_d, sec_d} = dec_time(min_q, sec_q);
         done_d         = final_dec;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         min_q  <= 6'd0;
         sec_q  <= 6'd0;
         done_q <= 1'b0;
      end else begin
         min_q  <= min_d;
         sec_q  <= sec_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      o_min  = min_q;
      o_sec  = sec_q;
      o_run  = (state_q == ST_RUN);
      o_done = done_q;
   end

endmodule
